// File: rtl/wave_record.sv
// WAV capture engine: samples a signed 16-bit PCM stream at a fixed rate and
// writes a complete mono 16-bit WAV image byte by byte over a write/ready port.
module wave_record #(
  parameter int CLK_RATE    = 24000000,
  parameter int SAMPLE_RATE = 48000,
  parameter int MAX_DATA    = 16777216
) (
  input  logic        I_CLK,
  input  logic        I_RSTn,
  input  logic        I_START,
  input  logic        I_STOP,
  input  logic [27:0] I_BASE_ADDR,
  input  logic [15:0] I_PCM,
  output logic [27:0] O_ADDR,
  output logic [7:0]  O_DATA,
  output logic        O_WRITE,
  input  logic        I_READY,
  output logic        O_BUSY,
  output logic        O_DONE,
  output logic        O_OVERRUN,
  output logic [27:0] O_LENGTH
);

  typedef enum logic [1:0] {S_IDLE, S_HDR, S_REC, S_PATCH} state_t;

  localparam logic [31:0] CLK_L = 32'(CLK_RATE);
  localparam logic [31:0] SR_L  = 32'(SAMPLE_RATE);
  localparam logic [31:0] BR_L  = 32'(2 * SAMPLE_RATE);
  localparam logic [27:0] MAX_L = 28'(MAX_DATA);

  state_t      state_q;
  logic [27:0] base_q, addr_q, len_q;
  logic [7:0]  data_q, pcm_hi_q;
  logic [5:0]  idx_q;
  logic [31:0] acc_q;
  logic        wr_q, wait_q, busy_q, done_q, ovr_q;
  logic        stop_q, samp_q, hi_q;

  logic [31:0] acc_sum, acc_d;
  logic        tick, ack, stop_now;
  logic [5:0]  idx_nxt;

  // Fixed 44-byte header; the two size fields stay zero until patched.
  function automatic logic [7:0] hdr_byte(input logic [5:0] i);
    logic [7:0] b;
    b = 8'h00;
    case (i)
      6'd0:  b = 8'h52;
      6'd1:  b = 8'h49;
      6'd2:  b = 8'h46;
      6'd3:  b = 8'h46;
      6'd8:  b = 8'h57;
      6'd9:  b = 8'h41;
      6'd10: b = 8'h56;
      6'd11: b = 8'h45;
      6'd12: b = 8'h66;
      6'd13: b = 8'h6d;
      6'd14: b = 8'h74;
      6'd15: b = 8'h20;
      6'd16: b = 8'h10;
      6'd20: b = 8'h01;
      6'd22: b = 8'h01;
      6'd24: b = SR_L[7:0];
      6'd25: b = SR_L[15:8];
      6'd26: b = SR_L[23:16];
      6'd27: b = SR_L[31:24];
      6'd28: b = BR_L[7:0];
      6'd29: b = BR_L[15:8];
      6'd30: b = BR_L[23:16];
      6'd31: b = BR_L[31:24];
      6'd32: b = 8'h02;
      6'd34: b = 8'h10;
      6'd36: b = 8'h64;
      6'd37: b = 8'h61;
      6'd38: b = 8'h74;
      6'd39: b = 8'h61;
      default: b = 8'h00;
    endcase
    return b;
  endfunction

  // Patch bytes 0..3 are the RIFF size (36+len), bytes 4..7 the data size.
  function automatic logic [7:0] patch_byte(input logic [2:0] i, input logic [27:0] len);
    logic [31:0] w;
    w = i[2] ? {4'd0, len} : {4'd0, len} + 32'd36;
    return w[{i[1:0], 3'b000} +: 8];
  endfunction

  function automatic logic [27:0] patch_addr(input logic [2:0] i, input logic [27:0] base);
    return base + (i[2] ? 28'd40 : 28'd4) + {26'd0, i[1:0]};
  endfunction

  // NOTE: every variable assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    acc_sum  = acc_q + SR_L;
    acc_d    = acc_q;
    tick     = 1'b0;
    if (state_q == S_REC) begin
      if (acc_sum >= CLK_L) begin
        tick  = 1'b1;
        acc_d = acc_sum - CLK_L;
      end else begin
        acc_d = acc_sum;
      end
    end
    ack      = wait_q & I_READY;
    stop_now = I_STOP | stop_q | (len_q >= MAX_L);
    idx_nxt  = idx_q + 6'd1;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge I_CLK or negedge I_RSTn) begin
    if (!I_RSTn) begin
      state_q  <= S_IDLE;
      base_q   <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      len_q    <= '0;
      pcm_hi_q <= '0;
      idx_q    <= '0;
      acc_q    <= '0;
      wr_q     <= 1'b0;
      wait_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovr_q    <= 1'b0;
      stop_q   <= 1'b0;
      samp_q   <= 1'b0;
      hi_q     <= 1'b0;
    end else begin
      wr_q   <= 1'b0;
      done_q <= 1'b0;
      // The write cycle itself never acknowledges; waiting starts the cycle after.
      if (wr_q)     wait_q <= 1'b1;
      else if (ack) wait_q <= 1'b0;

      case (state_q)
        S_IDLE: begin
          if (I_START) begin
            state_q <= S_HDR;
            base_q  <= I_BASE_ADDR;
            len_q   <= '0;
            ovr_q   <= 1'b0;
            stop_q  <= 1'b0;
            samp_q  <= 1'b0;
            hi_q    <= 1'b0;
            acc_q   <= '0;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            wr_q    <= 1'b1;
            addr_q  <= I_BASE_ADDR;
            data_q  <= hdr_byte(6'd0);
          end
        end

        S_HDR: begin
          if (I_STOP) stop_q <= 1'b1;
          if (ack) begin
            if (idx_q == 6'd43) begin
              state_q <= S_REC;
            end else begin
              idx_q  <= idx_nxt;
              wr_q   <= 1'b1;
              addr_q <= base_q + {22'd0, idx_nxt};
              data_q <= hdr_byte(idx_nxt);
            end
          end
        end

        S_REC: begin
          acc_q <= acc_d;
          if (samp_q) begin
            if (I_STOP) stop_q <= 1'b1;
            if (tick)   ovr_q  <= 1'b1;
            if (ack) begin
              len_q <= len_q + 28'd1;
              if (hi_q) begin
                samp_q <= 1'b0;
              end else begin
                hi_q   <= 1'b1;
                wr_q   <= 1'b1;
                addr_q <= addr_q + 28'd1;
                data_q <= pcm_hi_q;
              end
            end
          end else if (stop_now) begin
            state_q <= S_PATCH;
            idx_q   <= '0;
            wr_q    <= 1'b1;
            addr_q  <= patch_addr(3'd0, base_q);
            data_q  <= patch_byte(3'd0, len_q);
          end else if (tick) begin
            samp_q   <= 1'b1;
            hi_q     <= 1'b0;
            pcm_hi_q <= I_PCM[15:8];
            wr_q     <= 1'b1;
            addr_q   <= base_q + 28'd44 + len_q;
            data_q   <= I_PCM[7:0];
          end
        end

        S_PATCH: begin
          if (ack) begin
            if (idx_q[2:0] == 3'd7) begin
              state_q <= S_IDLE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              idx_q  <= idx_nxt;
              wr_q   <= 1'b1;
              addr_q <= patch_addr(idx_nxt[2:0], base_q);
              data_q <= patch_byte(idx_nxt[2:0], len_q);
            end
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign O_ADDR    = addr_q;
  assign O_DATA    = data_q;
  assign O_WRITE   = wr_q;
  assign O_BUSY    = busy_q;
  assign O_DONE    = done_q;
  assign O_OVERRUN = ovr_q;
  assign O_LENGTH  = len_q;

endmodule

// File: doc/wave_record.md
# wave_record

Audio capture engine: samples a signed 16-bit PCM stream at a fixed rate and writes a complete mono 16-bit WAV image, byte by byte, into DDRAM through the same byte-wide write handshake the wav loader drives. Write side of the WAV path; its output plays back through `wave_sound` unchanged. Sits between the core's audio mix and the `ddram` byte port, which it shares with the loader and player under top-level muxing.

## Interface
- CLK_RATE, 24000000: I_CLK frequency in Hz.
- SAMPLE_RATE, 48000: capture rate in Hz; also written into the header.
- MAX_DATA, 16777216: data-chunk byte limit; must be even.

- I_CLK  in  1  system clock.
- I_RSTn  in  1  reset, asynchronous, active-low.
- I_START  in  1  one-cycle pulse, begin recording; ignored while O_BUSY=1.
- I_STOP  in  1  one-cycle pulse, end recording; ignored while idle.
- I_BASE_ADDR  in  28  byte address of the WAV image; latched on accepted I_START.
- I_PCM  in  16  signed sample; sampled only on a sample tick.
- O_ADDR  out  28  byte write address.
- O_DATA  out  8  byte write data.
- O_WRITE  out  1  one-cycle write request.
- I_READY  in  1  memory ready for the next write.
- O_BUSY  out  1  recording or patching in progress.
- O_DONE  out  1  one-cycle pulse when the image is complete.
- O_OVERRUN  out  1  sticky; a sample was dropped. Cleared on accepted I_START.
- O_LENGTH  out  28  data-chunk bytes written so far.

## Operation
- States: IDLE -> HDR -> REC -> PATCH -> IDLE.
- IDLE: outputs quiescent. An accepted I_START latches the base address, zeroes O_LENGTH, clears O_OVERRUN and enters HDR.
- HDR: writes the 44 header bytes to base+0..base+43, in this order: "RIFF", 00 00 00 00, "WAVE", "fmt ", 10 00 00 00, 01 00, 01 00, SAMPLE_RATE (4 bytes LE), 2*SAMPLE_RATE (4 bytes LE), 02 00, 10 00, "data", 00 00 00 00. Then enters REC.
- Tick generator: 32-bit phase accumulator, zeroed when HDR is entered. Accumulates only in REC. Each cycle, acc += SAMPLE_RATE. If acc >= CLK_RATE, then acc -= CLK_RATE and a tick fires.
- REC: on a tick with no sample pending, I_PCM is captured. It is written as the low byte to base+44+O_LENGTH, then the high byte to the next address. O_LENGTH increments by 1 per acknowledged byte.
- Overrun: a tick that arrives while either byte of the previous sample is still outstanding drops the new sample. It sets O_OVERRUN and writes nothing.
- Stop: I_STOP, or O_LENGTH reaching MAX_DATA, requests a stop. A stop requested during HDR is held until the header completes. A stop during a sample is held until both of its bytes are acknowledged. Stop then enters PATCH; no further ticks are taken.
- PATCH: writes 36+O_LENGTH (LE) to base+4..7, then O_LENGTH (LE) to base+40..43. O_DONE pulses, O_BUSY drops, state returns to IDLE. O_LENGTH holds its final value until the next start.
- I_START while busy is ignored. I_START and I_STOP in the same cycle while idle: start is accepted, stop is ignored.
- Reset, including mid-write: all outputs go to 0 immediately and state goes to IDLE. A pending write is abandoned.

## Timing
- Reset values: O_ADDR=0, O_DATA=0, O_WRITE=0, O_BUSY=0, O_DONE=0, O_OVERRUN=0, O_LENGTH=0.
- Write handshake:
  - O_WRITE is high for exactly one cycle, with O_ADDR/O_DATA valid in that cycle.
  - O_ADDR/O_DATA stay stable until acknowledge.
  - I_READY is ignored in the O_WRITE cycle. Acknowledge is the first later cycle with I_READY=1.
  - The next O_WRITE is at the earliest the cycle after the acknowledge.
- Start latency: O_BUSY rises and the first header O_WRITE occurs in the cycle after the accepted I_START.
- Tick latency: I_PCM is captured in the tick cycle. The low-byte O_WRITE follows in the next cycle.
- O_DONE pulses in the cycle after the acknowledge of the last patch byte. O_BUSY falls in that same cycle.

## Test plan
- Header: CLK_RATE=480, SAMPLE_RATE=48, base 0x100, I_READY returns 2 cycles after each O_WRITE. Expect 44 writes, 0x100=0x52 ('R') through 0x12B=0x00. Expect 0x118..0x11B = 30 00 00 00 and 0x11C..0x11F = 60 00 00 00.
- Samples: same setup, I_PCM=0x1234 then 0xABCD. Expect 0x12C=0x34, 0x12D=0x12, 0x12E=0xCD, 0x12F=0xAB. Ticks are 10 cycles apart.
- Stop after 3 samples: expect 0x104..0x107 = 2A 00 00 00 and 0x128..0x12B = 06 00 00 00. Expect O_LENGTH=6, one O_DONE pulse, O_BUSY=0.
- Slow memory: I_READY latency 25 cycles with a 10-cycle tick. Expect O_OVERRUN=1, dropped samples absent from memory, and O_LENGTH even, counting only written bytes.
- Limit: MAX_DATA=4, no I_STOP. Expect auto-patch after 2 samples, with data size 04 00 00 00 and RIFF size 28 00 00 00.
- Reset mid-sample: pull I_RSTn low while a write is outstanding. Expect all outputs 0 immediately. A new I_START after release must rewrite the header from base+0.
